// File: rtl/md5_pkg.sv
// Shared definitions for the digest receive path: receiver state encoding,
// digest geometry and the helper that places one byte into a digest word.
package md5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int HASH_BYTES = 16;
    localparam int HASH_W     = 128;
    localparam int BYTE_CNT_W = $clog2(HASH_BYTES);

    // Byte k of the digest sits k bytes down from the most significant end,
    // so the first byte received ends up as the most significant byte.
    function automatic logic [HASH_W-1:0] put_byte(
        input logic [HASH_W-1:0]     vec,
        input logic [BYTE_CNT_W-1:0] k,
        input logic [7:0]            b
    );
        logic [HASH_W-1:0] v;
        v = vec;
        v[HASH_W-1 - 8*int'(k) -: 8] = b;
        return v;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop input synchronizer, 16x oversample tick,
// start/data/stop FSM and shift register. Besides the registered byte/error
// pulses it exposes same-cycle strobes so the digest assembler can commit a
// byte in the very cycle the registered byte_valid goes high.
module uart_rx_byte
    import md5_pkg::*;
#(
    parameter int fsm_clk_freq = 16000000,
    parameter int baud         = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_byte_data,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_busy,
    output logic       o_start,
    output logic       o_byte_done,
    output logic       o_frame_bad,
    output logic [7:0] o_shift
);

    localparam int DIV = fsm_clk_freq / (baud * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    rx_state_t     r_state;
    logic [1:0]    r_sync;
    logic [DW-1:0] r_div_cnt;
    logic [3:0]    r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic          r_err_wait;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte_data;
    logic          r_byte_valid;
    logic          r_frame_err;

    logic w_rs;
    logic w_tick;
    logic w_mid_start;
    logic w_bit_sample;
    logic w_stop_sample;

    assign w_rs          = r_sync[1];
    assign w_tick        = (r_state != IDLE) && (r_div_cnt == DW'(DIV - 1));
    assign w_mid_start   = (r_state == START) && w_tick && (r_tick_cnt == 4'd7);
    assign w_bit_sample  = (r_state == DATA) && w_tick && (r_tick_cnt == 4'd15);
    assign w_stop_sample = (r_state == STOP) && !r_err_wait && w_tick && (r_tick_cnt == 4'd15);

    assign o_start      = (r_state == IDLE) && !w_rs;
    assign o_byte_done  = w_stop_sample && w_rs;
    assign o_frame_bad  = w_stop_sample && !w_rs;
    assign o_busy       = (r_state != IDLE);
    assign o_shift      = r_shift;
    assign o_byte_data  = r_byte_data;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

    // Synchronizer, tick divider, frame FSM and registered output pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync       <= 2'b11;
            r_state      <= IDLE;
            r_div_cnt    <= '0;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_err_wait   <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_rx};
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            // The divider is parked at zero in IDLE so the first tick of a
            // frame lands exactly DIV clocks after the start edge.
            if (r_state == IDLE || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (!w_rs) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (w_mid_start) begin
                        r_tick_cnt <= '0;
                        r_state    <= w_rs ? IDLE : DATA;
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (w_bit_sample) begin
                        r_tick_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (r_err_wait) begin
                        // A low stop bit may be a break; hold until the line idles.
                        if (w_rs) begin
                            r_err_wait <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end else if (w_stop_sample) begin
                        r_tick_cnt <= '0;
                        if (w_rs) begin
                            r_byte_data  <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_wait  <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Data bits arrive LSB first; each mid-bit sample lands in its slot.
    always_ff @(posedge clk) begin
        if (w_bit_sample) begin
            r_shift[r_bit_cnt] <= w_rs;
        end
    end

endmodule

// File: rtl/hash_loader_rx.sv
// Receives a 16-byte target MD5 digest over UART and presents it to the
// generator's compare register. Bytes collect in a staging register; the
// visible digest changes only when a complete frame of 16 good bytes is in.
// A partial digest is dropped on a bad stop bit or after a long idle gap.
module hash_loader_rx
    import md5_pkg::*;
#(
    parameter int fsm_clk_freq   = 16000000,
    parameter int baud           = 9600,
    parameter int timeout_cycles = 16000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    output logic [0:HASH_W-1] hash_out,
    output logic              hash_valid,
    output logic              frame_err,
    output logic              rx_led
);

    localparam int TO_W = $clog2(timeout_cycles + 1);

    logic [BYTE_CNT_W-1:0] r_byte_count;
    logic [TO_W-1:0]       r_idle_cnt;
    logic [HASH_W-1:0]     r_staging;
    logic [HASH_W-1:0]     r_hash_out;
    logic                  r_hash_valid;

    logic       w_busy;
    logic       w_start;
    logic       w_byte_done;
    logic       w_frame_bad;
    logic [7:0] w_shift;
    logic       w_active;
    logic       w_last_byte;
    logic       w_expire;

    uart_rx_byte #(
        .fsm_clk_freq (fsm_clk_freq),
        .baud         (baud)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (rx),
        .o_byte_data  (byte_data),
        .o_byte_valid (byte_valid),
        .o_frame_err  (frame_err),
        .o_busy       (w_busy),
        .o_start      (w_start),
        .o_byte_done  (w_byte_done),
        .o_frame_bad  (w_frame_bad),
        .o_shift      (w_shift)
    );

    // A start edge seen this cycle counts as activity, so it beats a
    // simultaneous timeout and the partial digest survives.
    assign w_active    = w_busy || w_start;
    assign w_last_byte = (r_byte_count == BYTE_CNT_W'(HASH_BYTES - 1));
    assign w_expire    = !w_active && (r_byte_count != '0) &&
                         (r_idle_cnt == TO_W'(timeout_cycles - 1));

    assign hash_out   = r_hash_out;
    assign hash_valid = r_hash_valid;
    assign rx_led     = w_busy;

    // Byte position, inter-byte idle timer and digest commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_byte_count <= '0;
            r_idle_cnt   <= '0;
            r_hash_out   <= '0;
            r_hash_valid <= 1'b0;
        end else begin
            r_hash_valid <= 1'b0;

            if (w_frame_bad) begin
                r_byte_count <= '0;
            end else if (w_byte_done) begin
                if (w_last_byte) begin
                    r_byte_count <= '0;
                    r_hash_out   <= put_byte(r_staging, r_byte_count, w_shift);
                    r_hash_valid <= 1'b1;
                end else begin
                    r_byte_count <= r_byte_count + BYTE_CNT_W'(1);
                end
            end else if (w_expire) begin
                r_byte_count <= '0;
            end

            if (w_active || (r_byte_count == '0) || w_expire) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + TO_W'(1);
            end
        end
    end

    // Staging lanes are overwritten in order; resetting the byte position is
    // enough to discard a partial digest.
    always_ff @(posedge clk) begin
        if (w_byte_done) begin
            r_staging <= put_byte(r_staging, r_byte_count, w_shift);
        end
    end

endmodule

// File: tb/tb_hash_loader_rx.sv
// Directed bench for hash_loader_rx, run at a fast bit rate (DIV = 2).
module tb_hash_loader_rx;

    localparam int CLK_HZ = 3200000;
    localparam int BAUD   = 100000;
    localparam int TO_CYC = 1000;
    localparam int DIV    = CLK_HZ / (BAUD * 16);
    localparam int BIT    = 16 * DIV;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic [0:127] hash_out;
    logic         hash_valid;
    logic         frame_err;
    logic         rx_led;

    int n_chk = 0;
    int n_err = 0;
    int n_bv = 0, n_hv = 0, n_fe = 0, n_led = 0;
    int n_dbl = 0, n_excl = 0, n_hv_alone = 0;
    logic p_bv = 1'b0, p_hv = 1'b0, p_fe = 1'b0;

    always #5 clk = ~clk;

    hash_loader_rx #(
        .fsm_clk_freq   (CLK_HZ),
        .baud           (BAUD),
        .timeout_cycles (TO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .hash_out   (hash_out),
        .hash_valid (hash_valid),
        .frame_err  (frame_err),
        .rx_led     (rx_led)
    );

    // Pulse counters and pulse-shape rule tracking.
    always @(negedge clk) begin
        if (byte_valid) n_bv <= n_bv + 1;
        if (hash_valid) n_hv <= n_hv + 1;
        if (frame_err)  n_fe <= n_fe + 1;
        if (rx_led)     n_led <= n_led + 1;
        if ((byte_valid && p_bv) || (hash_valid && p_hv) || (frame_err && p_fe)) n_dbl <= n_dbl + 1;
        if (byte_valid && frame_err) n_excl <= n_excl + 1;
        if (hash_valid && !byte_valid) n_hv_alone <= n_hv_alone + 1;
        p_bv <= byte_valid;
        p_hv <= hash_valid;
        p_fe <= frame_err;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127 - 8*i -: 8];
    endfunction

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [127:0] d1, h2, h3, f1, f2, ta;
        int b0, h0, f0, l0;
        d1 = 128'he4cec1b40fa014fe06f207755a9c2087;
        h2 = 128'h000102030405060708090a0b0c0d0e0f;
        h3 = 128'h0123456789abcdeffedcba9876543210;
        f1 = 128'h00112233445566778899aabbccddeeff;
        f2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        ta = 128'haaaaaaaaaaaaaaaabbbbbbbbbbbbbbbb;

        reset = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rst_ctl", {byte_data, byte_valid, hash_valid, frame_err, rx_led}, '0);
        check("rst_hash", hash_out, '0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Digest load
        b0 = n_bv; h0 = n_hv; f0 = n_fe;
        for (int i = 0; i < 16; i++) begin
            send_byte(byte_of(d1, i), 1'b1);
            #2;
            check($sformatf("load_byte%0d", i), byte_data, byte_of(d1, i));
            if (i == 14) check("load_no_early_hv", n_hv - h0, 0);
        end
        check("load_bv_count", n_bv - b0, 16);
        check("load_hv_count", n_hv - h0, 1);
        check("load_hash", hash_out, d1);
        check("load_no_ferr", n_fe - f0, 0);

        // Glitch shorter than half a bit
        repeat (BIT) @(negedge clk);
        b0 = n_bv; l0 = n_led;
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        #2;
        check("glitch_no_bv", n_bv - b0, 0);
        check("glitch_idle", rx_led, 0);
        check("glitch_led_brief", ((n_led - l0) > 0) && ((n_led - l0) <= 8 * DIV + 4), 1);

        // Bad stop bit discards the partial digest
        b0 = n_bv; h0 = n_hv; f0 = n_fe;
        for (int i = 0; i < 5; i++) send_byte(8'ha0 + 8'(i), 1'b1);
        send_byte(8'h41, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        #2;
        check("bad_ferr_count", n_fe - f0, 1);
        check("bad_hash_kept", hash_out, d1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        #2;
        check("bad_hash", hash_out, h2);
        check("bad_hv_count", n_hv - h0, 1);
        check("bad_bv_count", n_bv - b0, 21);
        check("bad_ferr_once", n_fe - f0, 1);

        // Gap shorter than the timeout keeps the partial digest
        h0 = n_hv;
        for (int i = 0; i < 8; i++) send_byte(8'haa, 1'b1);
        repeat (600) @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(8'hbb, 1'b1);
        #2;
        check("short_gap_hash", hash_out, ta);
        check("short_gap_hv", n_hv - h0, 1);

        // Gap longer than the timeout discards it
        h0 = n_hv;
        for (int i = 0; i < 8; i++) send_byte(8'h11, 1'b1);
        repeat (1200) @(negedge clk);
        #2;
        check("timeout_hash_kept", hash_out, ta);
        check("timeout_no_hv", n_hv - h0, 0);
        for (int i = 0; i < 16; i++) send_byte(8'hff, 1'b1);
        #2;
        check("timeout_hash", hash_out, {128{1'b1}});
        check("timeout_hv", n_hv - h0, 1);

        // Reset during the data bits of the third byte
        repeat (BIT) @(negedge clk);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT + BIT / 2) @(negedge clk);
        #1;
        check("rst_mid_busy", rx_led, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_ctl", {byte_data, byte_valid, hash_valid, frame_err, rx_led}, '0);
        check("rst_mid_hash", hash_out, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        h0 = n_hv;
        for (int i = 0; i < 16; i++) send_byte(byte_of(h3, i), 1'b1);
        #2;
        check("rst_reload_hash", hash_out, h3);
        check("rst_reload_hv", n_hv - h0, 1);

        // Back-to-back frames
        h0 = n_hv;
        for (int i = 0; i < 32; i++) begin
            send_byte((i < 16) ? byte_of(f1, i) : byte_of(f2, i - 16), 1'b1);
            if (i == 15 || i == 30) begin
                #2;
                check($sformatf("b2b_hold%0d", i), hash_out, f1);
                check($sformatf("b2b_hv%0d", i), n_hv - h0, 1);
            end
        end
        #2;
        check("b2b_hash2", hash_out, f2);
        check("b2b_hv_total", n_hv - h0, 2);

        check("pulse_single", n_dbl, 0);
        check("bv_ferr_exclusive", n_excl, 0);
        check("hv_with_bv", n_hv_alone, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hash_loader_rx.md
Name: hash_loader_rx

Overview:
- UART 8N1 receiver that assembles 16 received bytes into the 128-bit target MD5 digest for the brute-force generator.
- It is the receive-side counterpart of the existing usart transmitter, which reports the cleartext.
- It sits between the board rx pin and the generator's target-compare register.
- The digest is held stable until the next complete 16-byte frame replaces it.

Parameters:
- fsm_clk_freq, 16000000, system clock in Hz.
- baud, 9600, serial bit rate.
- timeout_cycles, 16000000, idle clocks after a partial digest before the partial is discarded.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input, idles high.
- byte_data  out  8  last correctly framed byte.
- byte_valid  out  1  one-cycle pulse when byte_data updates.
- hash_out  out  128  target digest, declared [0:127]; byte k occupies [8k:8k+7]; the first received byte is the most significant.
- hash_valid  out  1  one-cycle pulse when hash_out updates.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- rx_led  out  1  high while a frame is in progress (START through STOP).

Behaviour:
- Reset (reset low at a clk edge):
  - All outputs go to 0; hash_out = 128'd0.
  - FSM goes to IDLE; byte_count = 0; tick counters = 0.
  - The synchronizer loads 1s.
  - Reset mid-frame abandons the frame and the partial digest; no pulses are produced.
- Input sync: two-flop synchronizer on rx. All decisions use the synchronized value rs.
- Oversample tick:
  - DIV = fsm_clk_freq / (baud*16), integer division; the default is 104.
  - A tick pulses for one clk every DIV clocks.
  - The tick counter restarts at 0 when leaving IDLE, so sampling is aligned to the start edge.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - rs = 0 moves the FSM to START and clears tick_cnt and bit_cnt.
- START:
  - At the 8th tick (mid-bit), sample rs.
  - rs = 1 is a false start: return to IDLE with no output.
  - rs = 0: go to DATA with tick_cnt = 0.
- DATA:
  - Every 16th tick, sample rs into shift[bit_cnt]; data is sent LSB first.
  - After bit_cnt = 7, go to STOP.
- STOP:
  - At the 16th tick, sample rs.
  - rs = 1:
    - byte_data <= shift and byte_valid pulses.
    - hash_out byte byte_count is written through a staging register.
    - byte_count increments.
  - rs = 0:
    - frame_err pulses; the byte is dropped.
    - byte_count = 0; the partial digest is discarded.
    - The FSM waits in STOP until rs = 1 before returning to IDLE.
  - In both cases the FSM returns to IDLE.
- Staging vs. hash_out:
  - Bytes accumulate in a 128-bit staging register; hash_out itself is unchanged during assembly.
  - When the 16th good byte is latched (byte_count wraps 15 -> 0):
    - hash_out <= staging with that byte merged in.
    - hash_valid pulses in the same cycle as byte_valid.
- Inter-byte timeout:
  - The idle counter runs only while byte_count != 0 and the FSM is in IDLE.
  - It clears on any exit from IDLE.
  - At timeout_cycles: byte_count = 0, the staging content is discarded, and hash_out is unchanged. No pulse is produced.
- Simultaneous events:
  - If timeout expiry coincides with a start edge, the start wins and the counter clears; the partial digest is kept.
  - frame_err and byte_valid are mutually exclusive.
- Pulses: byte_valid, hash_valid and frame_err are never high for more than one consecutive cycle.
- Latency: byte_valid rises 2 clk (synchronizer) plus DIV*(8+16*9) clocks after the falling start edge at the pin, within one clk.

Decomposition:
- Shared package md5_pkg holds:
  - the FSM state encoding (localparams IDLE/START/DATA/STOP);
  - HASH_BYTES = 16;
  - the digest width of 128.
- One natural sub-module: uart_rx_byte.
  - Contains the synchronizer, tick generator, FSM and shift register.
  - Outputs byte_data, byte_valid, frame_err and busy.
- hash_loader_rx wraps uart_rx_byte with byte_count, the staging register, the timeout counter and hash_out.

Test Plan:
- Digest load: at 9600 baud, send 16 bytes e4 ce c1 b4 0f a0 14 fe 06 f2 07 75 5a 9c 20 87.
  - 16 byte_valid pulses.
  - A single hash_valid pulse on the last one.
  - hash_out = 128'he4cec1b40fa014fe06f207755a9c2087.
  - frame_err never asserts.
- Glitch: drive rx low for 3*DIV clocks, then high.
  - No byte_valid; FSM back in IDLE; rx_led high only briefly.
- Bad stop bit: send 5 good bytes, then byte 0x41 with stop = 0, then 16 good bytes 00..0f.
  - One frame_err pulse.
  - hash_out = 128'h000102030405060708090a0b0c0d0e0f.
- Timeout: set timeout_cycles = 1000 and send 8 bytes.
  - Idle more than 1000 clk, then send 16 bytes of 0xff.
  - hash_out = all ones; exactly one hash_valid.
- Reset mid-frame: assert reset during DATA of byte 3.
  - All outputs 0 the next cycle.
  - A subsequent full 16-byte frame loads correctly.
- Back-to-back: 32 bytes with no inter-frame gap.
  - Two hash_valid pulses.
  - hash_out holds the first digest until the second frame's last byte.
